// File: rtl/fmap_stream_reader_pkg.sv
// cnn_fmap_pkg: shared tile geometry and reader FSM states for the feature-map stream reader.
package cnn_fmap_pkg;
  localparam int FMAP_ROWS = 4;
  localparam int FMAP_COLS = 4;
  localparam int FMAP_DW = 8;
  localparam int FMAP_AW = 3;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/fmap_stream_reader_addr_gen.sv
// fmap_addr_gen: row/col scan counters for one tile; FMAP_COLMAJOR_EN selects column-major order.
module fmap_addr_gen import cnn_fmap_pkg::*; #(
  parameter int ROWS = FMAP_ROWS,
  parameter int COLS = FMAP_COLS,
  parameter int AW = FMAP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          is_last
);
  localparam logic [AW-1:0] ROW_MAX = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_MAX = AW'(COLS - 1);
  logic row_end, col_end;
  logic [AW-1:0] row_nxt, col_nxt;
  assign row_end = row == ROW_MAX;
  assign col_end = col == COL_MAX;
  assign is_last = row_end && col_end;
`ifdef FMAP_COLMAJOR_EN
  assign row_nxt = row_end ? '0 : row + 1'b1;
  assign col_nxt = row_end ? (col_end ? '0 : col + 1'b1) : col;
`else
  assign col_nxt = col_end ? '0 : col + 1'b1;
  assign row_nxt = col_end ? (row_end ? '0 : row + 1'b1) : row;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      row <= row_nxt;
      col <= col_nxt;
    end
endmodule

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: streams one tile from the scratch memory as valid/ready with last-flag.
// Scan order is row-major unless FMAP_COLMAJOR_EN is defined (column-major).
module fmap_stream_reader import cnn_fmap_pkg::*; #(
  parameter int ROWS = FMAP_ROWS,
  parameter int COLS = FMAP_COLS,
  parameter int DW = FMAP_DW,
  parameter int AW = FMAP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_addr1,
  input  logic [DW-1:0] mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  state_t state, nxt;
  logic capture, is_last;
  logic [AW-1:0] row, col;
  assign capture = state == READ && (!out_valid || out_ready);
  fmap_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_addr (
    .clk(clk), .reset(reset), .clr(state != READ), .adv(capture),
    .row(row), .col(col), .is_last(is_last)
  );
  assign mem_rd_en = state == READ;
  assign mem_addr = mem_rd_en ? row : '0;
  assign mem_addr1 = mem_rd_en ? col : '0;
  assign busy = state == READ || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? READ : IDLE;
      READ:    nxt = capture && is_last ? DRAIN : READ;
      DRAIN:   nxt = out_ready ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // memory reads are combinational, so the output register is the only pipeline stage
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data <= mem_data;
      out_last <= is_last;
    end else if (state == DRAIN && out_ready) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end
endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
- Reads one 4x4 feature-map tile, 8-bit entries, out of the two-index scratch memory.
- Drives that memory's read side: rd_en, row index addr, column index addr1.
- Emits the entries as a valid/ready stream with a last-flag, for the next CNN stage (FC / serializer).
- Reads are combinational, so each element is captured into a one-entry output register.

Parameters:
- ROWS, 4, rows in the tile (addr range 0..ROWS-1)
- COLS, 4, columns in the tile (addr1 range 0..COLS-1)
- DW, 8, data width
- AW, 3, width of each memory index port

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to stream the tile; sampled only in IDLE
- mem_rd_en  out  1  memory read enable; memory writes are blocked while high
- mem_addr  out  AW  row index
- mem_addr1  out  AW  column index
- mem_data  in  DW  memory read data, combinational from mem_addr/mem_addr1
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  downstream accepts when valid and ready are both high
- out_data  out  DW  streamed element
- out_last  out  1  high with the final element (ROWS-1, COLS-1)
- busy  out  1  high in READ and DRAIN
- done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async, reset=0): state=IDLE.
  - row=col=0, mem_rd_en=0, mem_addr=mem_addr1=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1 go to READ; row=col=0.
- READ:
  - mem_rd_en=1; mem_addr=row, mem_addr1=col.
  - capture = !out_valid || out_ready.
  - On capture: out_data<=mem_data, out_valid<=1, out_last<=(row==ROWS-1 && col==COLS-1); then advance.
  - Advance is row-major: col+1; on col==COLS-1, col=0 and row+1.
  - When the last element is captured, go to DRAIN.
  - With no capture, row/col hold and out_data holds (stable under back-pressure).
- DRAIN:
  - mem_rd_en=0, addresses return to 0.
  - Hold out_valid/out_data/out_last until out_ready=1.
  - On that handshake: out_valid<=0, out_last<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- out_valid falls in READ only if a handshake occurs with no capture. This cannot happen, because capture is true whenever out_ready=1.
- Latency with start in cycle T and out_ready held 1:
  - busy and mem_rd_en high from T+1.
  - Element k (k=0..15) is valid in cycle T+2+k.
  - Element 15 with out_last is in T+17.
  - done is high in T+18; busy is low from T+18.
- start while not in IDLE: ignored, no restart and no queueing.
- out_ready=1 while out_valid=0: no effect.
- Reset mid-stream: immediate abort to reset values. No done pulse. The partial stream is not resumed.
- Indices are never outside 0..ROWS-1 / 0..COLS-1.

Optional Feature:
- Macro FMAP_COLMAJOR_EN.
- Defined: scan is column-major: row+1 first; on row==ROWS-1, row=0 and col+1.
  - out_last is unchanged: the final element is still (ROWS-1, COLS-1).
  - Latency and handshake are unchanged.
- Undefined: row-major scan as above.

Decomposition:
- Package cnn_fmap_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - constants FMAP_ROWS=4, FMAP_COLS=4, FMAP_DW=8, FMAP_AW=3.
- Sub-module fmap_addr_gen:
  - row/col counters with clear, advance and wrap;
  - produces an is_last flag;
  - selects the scan order under FMAP_COLMAJOR_EN.
- Top level holds the FSM and the output register.

Test Plan:
- Memory model with mem[r][c]=4r+c; start at T, out_ready=1 -> out_data 0..15 in cycles T+2..T+17, out_last only on 15, done only at T+18.
- out_ready low for 3 cycles while element 5 is valid -> out_data stays 5, mem_addr=1 and mem_addr1=2 held, then 6..15 follow with no loss or duplication.
- start pulsed again at T+6 -> ignored, exactly 16 elements and one done pulse.
- reset driven low at T+8 -> all outputs 0 immediately, state IDLE, no done; a fresh start then streams 0..15.
- out_ready=0 from T+17 for 4 cycles -> element 15 with out_last held, mem_rd_en=0, done only one cycle after the accepting edge.
- FMAP_COLMAJOR_EN defined, same memory model -> sequence 0,4,8,12,1,5,...,15 with out_last on 15.
